pci_master: RTL and testbench

//  Single-data-phase PCI bus initiator; counterpart to our PCI target. A local-side request
//  (cmd/addr/data/BE) becomes one bus transaction: REQ#/GNT# arbitration, address phase, one

---
 rtl/pci_pkg.sv | 29 ++
 rtl/pci_par_gen.sv | 23 ++
 rtl/pci_master.sv | 202 ++++++++++++++++++++
 tb/tb_pci_master.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared PCI definitions: command codes, completion status codes and master FSM states.
package pci_pkg;

  localparam logic [3:0] CMD_IO_RD  = 4'b0010;
  localparam logic [3:0] CMD_IO_WR  = 4'b0011;
  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;
  localparam logic [3:0] CMD_CFG_RD = 4'b1010;
  localparam logic [3:0] CMD_CFG_WR = 4'b1011;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_MABORT = 2'b01;
  localparam logic [1:0] ST_TABORT = 2'b10;
  localparam logic [1:0] ST_RETRY  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_TURN = 3'd4
  } state_t;

  // Odd command codes are the write flavours.
  function automatic logic is_write(input logic [3:0] cmd);
    return cmd[0];
  endfunction

endpackage

// File: rtl/pci_par_gen.sv
// Registered even parity over AD/CBE# plus a one-clock-delayed output enable,
// so PAR trails the data it covers by exactly one clock.
module pci_par_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ad,
  input  logic [3:0]  cbe_n,
  input  logic        oe_ad_n,
  output logic        par,
  output logic        oe_par_n
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par      <= 1'b0;
      oe_par_n <= 1'b1;
    end else begin
      par      <= ^{ad, cbe_n};
      oe_par_n <= oe_ad_n;
    end
  end

endmodule

// File: rtl/pci_master.sv
// Single-data-phase PCI initiator. Define PCI_MASTER_RETRY_EN to re-issue a
// target-retried request up to MAX_RETRY times before completing with status 11.
module pci_master
  import pci_pkg::*;
#(
  parameter int  DEVSEL_TIMEOUT = 5,
  parameter int  MAX_RETRY      = 16,
  localparam int RCW            = $clog2(MAX_RETRY + 1)
) (
  input  logic           CLK,
  input  logic           RST_N,
  // Local request: accepted on the rising edge where REQ_VALID & REQ_READY;
  // the initiator holds REQ_READY low until the completion pulse has been issued.
  input  logic           REQ_VALID,
  output logic           REQ_READY,
  input  logic [3:0]     REQ_CMD,
  input  logic [31:0]    REQ_ADDR,
  input  logic [31:0]    REQ_WDATA,
  input  logic [3:0]     REQ_BE_N,
  output logic           RSP_VALID,
  output logic [31:0]    RSP_RDATA,
  output logic [1:0]     RSP_STATUS,
  output logic           REQ_O_N,
  output logic           OE_REQ_N,
  input  logic           GNT_I_N,
  input  logic           FRAME_I_N,
  input  logic           IRDY_I_N,
  input  logic           TRDY_I_N,
  input  logic           DEVSEL_I_N,
  input  logic           STOP_I_N,
  output logic           FRAME_O_N,
  output logic           OE_FRAME_N,
  output logic           IRDY_O_N,
  output logic           OE_IRDY_N,
  input  logic [31:0]    AD_I,
  output logic [31:0]    AD_O,
  output logic           OE_AD_N,
  output logic [3:0]     CBE_O_N,
  output logic           OE_CBE_N,
  output logic           PAR_O,
  output logic           OE_PAR_N,
  output logic [2:0]     DBG_STATE,
  output logic [RCW-1:0] DBG_RETRY_CNT
);

  localparam logic [7:0]     DEV_LAST    = 8'(DEVSEL_TIMEOUT - 1);
  localparam logic [RCW-1:0] RETRY_LIMIT = RCW'(MAX_RETRY);

  state_t         state, next_state;
  logic [3:0]     req_cmd;
  logic [31:0]    req_addr;
  logic [31:0]    req_wdata;
  logic [3:0]     req_be_n;
  logic [7:0]     dcnt;
  logic [31:0]    rsp_rdata_q;
  logic [1:0]     rsp_status_q;
  logic           reissue_q;
  logic [RCW-1:0] retry_cnt;

  logic           data_done;
  logic           data_retry;
  logic [1:0]     data_status;
  logic [31:0]    data_rdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    REQ_READY   = 1'b0;
    REQ_O_N     = 1'b1;
    OE_REQ_N    = 1'b1;
    FRAME_O_N   = 1'b1;
    OE_FRAME_N  = 1'b1;
    IRDY_O_N    = 1'b1;
    OE_IRDY_N   = 1'b1;
    AD_O        = '0;
    OE_AD_N     = 1'b1;
    CBE_O_N     = 4'hF;
    OE_CBE_N    = 1'b1;
    RSP_VALID   = 1'b0;
    data_done   = 1'b0;
    data_retry  = 1'b0;
    data_status = ST_OK;
    data_rdata  = '0;

    // Data-phase outcome in priority order; only acted on in S_DATA.
    if (!TRDY_I_N) begin
      data_done  = 1'b1;
      data_rdata = is_write(req_cmd) ? 32'h0 : AD_I;
    end else if (!STOP_I_N && DEVSEL_I_N) begin
      data_done   = 1'b1;
      data_status = ST_TABORT;
    end else if (!STOP_I_N) begin
      data_done   = 1'b1;
      data_retry  = 1'b1;
      data_status = ST_RETRY;
    end else if (DEVSEL_I_N && dcnt == DEV_LAST) begin
      data_done   = 1'b1;
      data_status = ST_MABORT;
    end

    case (state)
      S_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) next_state = S_ARB;
      end
      S_ARB: begin
        REQ_O_N  = 1'b0;
        OE_REQ_N = 1'b0;
        if (!GNT_I_N && FRAME_I_N && IRDY_I_N) next_state = S_ADDR;
      end
      S_ADDR: begin
        OE_REQ_N   = 1'b0;
        FRAME_O_N  = 1'b0;
        OE_FRAME_N = 1'b0;
        AD_O       = req_addr;
        OE_AD_N    = 1'b0;
        CBE_O_N    = req_cmd;
        OE_CBE_N   = 1'b0;
        next_state = S_DATA;
      end
      S_DATA: begin
        OE_REQ_N   = 1'b0;
        OE_FRAME_N = 1'b0;
        IRDY_O_N   = 1'b0;
        OE_IRDY_N  = 1'b0;
        CBE_O_N    = req_be_n;
        OE_CBE_N   = 1'b0;
        // Reads leave AD undriven so the target can turn it around.
        if (is_write(req_cmd)) begin
          AD_O    = req_wdata;
          OE_AD_N = 1'b0;
        end
        if (data_done) next_state = S_TURN;
      end
      S_TURN: begin
        OE_REQ_N   = 1'b0;
        OE_IRDY_N  = 1'b0;
        RSP_VALID  = !reissue_q;
        next_state = reissue_q ? S_ARB : S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_cmd      <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_be_n     <= '1;
      dcnt         <= '0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= ST_OK;
      reissue_q    <= 1'b0;
      retry_cnt    <= '0;
    end else begin
      if (state == S_IDLE && REQ_VALID) begin
        req_cmd   <= REQ_CMD;
        req_addr  <= REQ_ADDR;
        req_wdata <= REQ_WDATA;
        req_be_n  <= REQ_BE_N;
        retry_cnt <= '0;
        reissue_q <= 1'b0;
      end
      if (state == S_ADDR)                      dcnt <= '0;
      else if (state == S_DATA && dcnt != 8'hFF) dcnt <= dcnt + 8'd1;
      if (state == S_DATA && data_done) begin
        rsp_status_q <= data_status;
        rsp_rdata_q  <= data_rdata;
        reissue_q    <= 1'b0;
        if (data_retry) begin
          retry_cnt <= retry_cnt + RCW'(1);
`ifdef PCI_MASTER_RETRY_EN
          if (retry_cnt < RETRY_LIMIT) reissue_q <= 1'b1;
`else
          if (retry_cnt > RETRY_LIMIT) reissue_q <= 1'b0;
`endif
        end
      end
    end
  end

  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_STATUS    = rsp_status_q;
  assign DBG_STATE     = state;
  assign DBG_RETRY_CNT = retry_cnt;

  pci_par_gen u_par (
    .clk      (CLK),
    .rst_n    (RST_N),
    .ad       (AD_O),
    .cbe_n    (CBE_O_N),
    .oe_ad_n  (OE_AD_N),
    .par      (PAR_O),
    .oe_par_n (OE_PAR_N)
  );

endmodule

// File: tb/tb_pci_master.sv
// Directed bench for pci_master: a behavioural target answers each address phase,
// completions are checked against an expected queue.
module tb_pci_master;
  import pci_pkg::*;

  logic        CLK, RST_N;
  logic        REQ_VALID, REQ_READY;
  logic [3:0]  REQ_CMD, REQ_BE_N;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_STATUS;
  logic        REQ_O_N, OE_REQ_N, GNT_I_N;
  logic        FRAME_I_N, IRDY_I_N, TRDY_I_N, DEVSEL_I_N, STOP_I_N;
  logic        FRAME_O_N, OE_FRAME_N, IRDY_O_N, OE_IRDY_N;
  logic [31:0] AD_I, AD_O;
  logic        OE_AD_N, OE_CBE_N, PAR_O, OE_PAR_N;
  logic [3:0]  CBE_O_N;
  logic [2:0]  DBG_STATE;
  logic [4:0]  DBG_RETRY_CNT;

  logic [33:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  pci_master dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_CMD(REQ_CMD),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_BE_N(REQ_BE_N),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_STATUS(RSP_STATUS),
    .REQ_O_N(REQ_O_N), .OE_REQ_N(OE_REQ_N), .GNT_I_N(GNT_I_N),
    .FRAME_I_N(FRAME_I_N), .IRDY_I_N(IRDY_I_N), .TRDY_I_N(TRDY_I_N),
    .DEVSEL_I_N(DEVSEL_I_N), .STOP_I_N(STOP_I_N),
    .FRAME_O_N(FRAME_O_N), .OE_FRAME_N(OE_FRAME_N),
    .IRDY_O_N(IRDY_O_N), .OE_IRDY_N(OE_IRDY_N),
    .AD_I(AD_I), .AD_O(AD_O), .OE_AD_N(OE_AD_N),
    .CBE_O_N(CBE_O_N), .OE_CBE_N(OE_CBE_N),
    .PAR_O(PAR_O), .OE_PAR_N(OE_PAR_N),
    .DBG_STATE(DBG_STATE), .DBG_RETRY_CNT(DBG_RETRY_CNT)
  );

  // Clock and watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: completions popped and compared mid-cycle.
  always @(negedge CLK) begin
    if (RSP_VALID === 1'b1) begin
      logic [33:0] e;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: observed status %0h data %0h with nothing expected",
               RSP_STATUS, RSP_RDATA);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_rdata", RSP_RDATA, e[31:0]);
        check("rsp_status", RSP_STATUS, e[33:32]);
      end
    end
  end

  // Driver: called at a negedge; returns just after the accepting edge.
  task automatic do_req(input logic [3:0] cmd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    int n = 0;
    REQ_VALID = 1'b1; REQ_CMD = cmd; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_BE_N = be;
    while (REQ_READY !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    check("req_ready_seen", REQ_READY, 1'b1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  // Behavioural target: asserts DEVSEL/TRDY/STOP from the given data clock (0 = never).
  task automatic target(input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int dev_c, input int trdy_c, input int stop_c,
                        input logic [31:0] rdata, output int wait_n, output int data_n);
    logic wr = cmd[0];
    bit   in_data = 1'b1;
    wait_n = 0;
    do begin @(negedge CLK); wait_n++; end
    while (!(FRAME_O_N === 1'b0 && OE_FRAME_N === 1'b0) && wait_n < 64);
    check("addr_phase_seen", {FRAME_O_N, OE_FRAME_N}, 2'b00);
    check("addr_ad", AD_O, addr);
    check("addr_cbe", CBE_O_N, cmd);
    data_n = 0;
    while (in_data) begin
      @(negedge CLK);
      if (IRDY_O_N !== 1'b0 || data_n >= 32) begin
        in_data = 1'b0;
      end else begin
        data_n++;
        if (data_n == 1) begin
          check("par_addr", {OE_PAR_N, PAR_O}, {1'b0, ^{addr, cmd}});
          check("data_cbe", CBE_O_N, be);
          check("data_oe_ad", OE_AD_N, !wr);
          if (wr) check("data_ad", AD_O, wdata);
        end
        if (data_n == 2) begin
          if (wr) check("par_wdata", {OE_PAR_N, PAR_O}, {1'b0, ^{wdata, be}});
          else    check("par_released", OE_PAR_N, 1'b1);
        end
        DEVSEL_I_N = !(dev_c != 0 && data_n >= dev_c);
        TRDY_I_N   = !(trdy_c != 0 && data_n >= trdy_c);
        STOP_I_N   = !(stop_c != 0 && data_n >= stop_c);
        AD_I       = TRDY_I_N ? 32'h0 : rdata;
      end
    end
    check("data_phase_bounded", data_n < 32, 1'b1);
    DEVSEL_I_N = 1'b1; TRDY_I_N = 1'b1; STOP_I_N = 1'b1; AD_I = 32'h0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge CLK); n++; end
    check("rsp_drained", exp_q.size(), 0);
  endtask

  initial begin
    int wn, dn;
    // Reset
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_CMD = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_BE_N = '1;
    GNT_I_N = 1'b0; FRAME_I_N = 1'b1; IRDY_I_N = 1'b1; TRDY_I_N = 1'b1;
    DEVSEL_I_N = 1'b1; STOP_I_N = 1'b1; AD_I = '0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_oe", {OE_REQ_N, OE_FRAME_N, OE_IRDY_N, OE_AD_N, OE_CBE_N, OE_PAR_N}, 6'h3F);
    check("rst_ctl", {REQ_O_N, FRAME_O_N, IRDY_O_N, RSP_VALID, PAR_O}, 5'b11100);
    check("rst_rsp", {RSP_STATUS, RSP_RDATA}, 34'h0);
    check("rst_idle", {REQ_READY, DBG_STATE, DBG_RETRY_CNT}, {1'b1, S_IDLE, 5'd0});

    // MEM_WR, slow DEVSEL, GNT already held
    exp_q.push_back({ST_OK, 32'h0});
    do_req(CMD_MEM_WR, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0000);
    target(CMD_MEM_WR, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0000, 3, 4, 0, 32'h0, wn, dn);
    check("latency_gnt_held", wn, 2);
    check("wr_data_clocks", dn, 4);
    wait_rsp();

    // IO_RD with late grant
    exp_q.push_back({ST_OK, 32'h1234_5678});
    GNT_I_N = 1'b1;
    do_req(CMD_IO_RD, 32'h0000_0010, 32'h0, 4'b0000);
    repeat (3) @(negedge CLK);
    check("arb_wait", {REQ_O_N, OE_REQ_N, OE_FRAME_N, DBG_STATE}, {3'b001, S_ARB});
    GNT_I_N = 1'b0;
    target(CMD_IO_RD, 32'h0000_0010, 32'h0, 4'b0000, 1, 2, 0, 32'h1234_5678, wn, dn);
    wait_rsp();

    // Disconnect with data is still a good completion
    exp_q.push_back({ST_OK, 32'hCAFE_F00D});
    do_req(CMD_CFG_RD, 32'h0000_0040, 32'h0, 4'b0011);
    target(CMD_CFG_RD, 32'h0000_0040, 32'h0, 4'b0011, 1, 1, 1, 32'hCAFE_F00D, wn, dn);
    wait_rsp();

    // Master abort: nobody claims the cycle
    exp_q.push_back({ST_MABORT, 32'h0});
    do_req(CMD_MEM_RD, 32'h4000_0000, 32'h0, 4'b0000);
    target(CMD_MEM_RD, 32'h4000_0000, 32'h0, 4'b0000, 0, 0, 0, 32'h0, wn, dn);
    check("mabort_clocks", dn, 5);
    check("mabort_turn", {OE_FRAME_N, OE_AD_N, OE_CBE_N, OE_IRDY_N, IRDY_O_N}, 5'b11101);
    @(negedge CLK);
    check("mabort_released", {OE_IRDY_N, OE_FRAME_N, DBG_STATE}, {2'b11, S_IDLE});
    wait_rsp();

    // Target abort
    exp_q.push_back({ST_TABORT, 32'h0});
    do_req(CMD_MEM_RD, 32'h3000_0000, 32'h0, 4'b0000);
    target(CMD_MEM_RD, 32'h3000_0000, 32'h0, 4'b0000, 0, 0, 2, 32'h0000_FFFF, wn, dn);
    wait_rsp();

    // Target retry
`ifdef PCI_MASTER_RETRY_EN
    exp_q.push_back({ST_OK, 32'hA5A5_5A5A});
    do_req(CMD_MEM_RD, 32'h2000_0000, 32'h0, 4'b0000);
    for (int i = 0; i < 3; i++)
      target(CMD_MEM_RD, 32'h2000_0000, 32'h0, 4'b0000, 1, 0, 1, 32'h0, wn, dn);
    target(CMD_MEM_RD, 32'h2000_0000, 32'h0, 4'b0000, 1, 1, 0, 32'hA5A5_5A5A, wn, dn);
    wait_rsp();
    check("retry_count", DBG_RETRY_CNT, 5'd3);

    exp_q.push_back({ST_RETRY, 32'h0});
    do_req(CMD_MEM_WR, 32'h2000_0100, 32'h1111_2222, 4'b0000);
    for (int i = 0; i < 17; i++)
      target(CMD_MEM_WR, 32'h2000_0100, 32'h1111_2222, 4'b0000, 1, 0, 1, 32'h0, wn, dn);
    wait_rsp();
    check("retry_exhausted", DBG_RETRY_CNT, 5'd17);
`else
    exp_q.push_back({ST_RETRY, 32'h0});
    do_req(CMD_MEM_RD, 32'h2000_0000, 32'h0, 4'b0000);
    target(CMD_MEM_RD, 32'h2000_0000, 32'h0, 4'b0000, 1, 0, 1, 32'h0, wn, dn);
    wait_rsp();
    check("retry_count", DBG_RETRY_CNT, 5'd1);
`endif

    // Reset in the middle of a data phase releases the bus immediately
    begin
      int n = 0;
      do_req(CMD_MEM_WR, 32'h5000_0000, 32'h5555_AAAA, 4'b0000);
      while (FRAME_O_N !== 1'b0 && n < 20) begin @(negedge CLK); n++; end
      check("rst_mid_addr_seen", FRAME_O_N, 1'b0);
      @(negedge CLK);
      check("rst_mid_in_data", DBG_STATE, S_DATA);
      RST_N = 1'b0;
      #1;
      check("rst_mid_oe", {OE_REQ_N, OE_FRAME_N, OE_IRDY_N, OE_AD_N, OE_CBE_N, OE_PAR_N}, 6'h3F);
      check("rst_mid_rsp", {RSP_VALID, DBG_STATE}, {1'b0, S_IDLE});
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
    end

    exp_q.push_back({ST_OK, 32'h0});
    do_req(CMD_IO_WR, 32'h0000_0020, 32'h0BAD_CAFE, 4'b1100);
    target(CMD_IO_WR, 32'h0000_0020, 32'h0BAD_CAFE, 4'b1100, 2, 2, 0, 32'h0, wn, dn);
    wait_rsp();
    @(negedge CLK);
    check("end_idle", {REQ_READY, OE_IRDY_N, DBG_STATE}, {2'b11, S_IDLE});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
